swd_memap_seq: RTL and testbench
================================

# swd_memap_seq

Memory-access sequencer that sits directly upstream of the SWD register interface (`swd_if`) in the AHB3-lite remote bridge. It turns single 32-bit-address memory reads and writes into the required DP/AP register transactions: power-up, AP select, CSW, TAR, DRW and RDBUFF. It caches the CSW size and the TAR value so that redundant SWD transactions are skipped. SWD errors are reported back to the requester as a single response code.

## Interface
Parameters:
- `CSW_BASE`, default `32'h2300_0000`: CSW value with the size field `[2:0]` cleared. Auto-increment is off.
- `PWRUP_VAL`, default `32'h5000_0000`: value written to DP CTRL/STAT to request debug and system power-up.

Ports (clock and reset first):
- `CLK` in 1: single clock for the whole block.
- `RESETn` in 1: reset. **Asynchronous, active-low.**
- `EN` in 1: link enable. Also drives `swd_if.EN`.
- `REQ_VALID` in 1: request valid.
- `REQ_READY` out 1: request accepted when `REQ_VALID & REQ_READY`.
- `REQ_ADDR` in 32: target byte address.
- `REQ_WDATA` in 32: write data, already placed on its byte lanes.
- `REQ_WRITE` in 1: 1 = write, 0 = read.
- `REQ_SIZE` in 2: 0 = byte, 1 = half, 2 = word, 3 = illegal.
- `RSP_VALID` out 1: one-cycle response pulse.
- `RSP_RDATA` out 32: read data, raw 32-bit DRW word with no lane shifting.
- `RSP_ERR` out 3: 0 = ok, otherwise the `swd_if` error code; 3'b111 = illegal size.
- `LINKUP` out 1: target powered and AP selected.
- `SWD_APNDP` out 1, `SWD_ADDR` out 2, `SWD_DATI` out 32, `SWD_WRITE` out 1, `SWD_VALID` out 1: transaction outputs to `swd_if`.
- `SWD_READY` in 1, `SWD_DATO` in 32, `SWD_ERR` in 3: transaction results from `swd_if`.
- `SWD_CLR` out 1: one-cycle pulse that clears the `swd_if` error.

## Operation
States: OFF, WAIT_LINK, INIT_PWR, INIT_SEL, IDLE, CSW, TAR, DRW, RDBUFF, RESP, FAIL.

**Issue sub-phase (every SWD state).**
- Drive `SWD_APNDP`/`SWD_ADDR`/`SWD_WRITE`/`SWD_DATI` and pulse `SWD_VALID` for exactly one cycle, and only while `SWD_READY`=1.
- Then wait until `SWD_READY` has been seen low and then high again. That rising edge is "done".
- Sample `SWD_DATO`/`SWD_ERR` on the done cycle.

**State transitions.**
- **OFF:** entered whenever `EN`=0, from any state, immediately. Invalidate all caches, drive `SWD_VALID`=0, `LINKUP`=0. Any in-flight request is dropped with no response. On `EN`=1, go to WAIT_LINK.
- **WAIT_LINK:** wait for `SWD_READY`=1 (IDCODE phase of `swd_if` complete). If `SWD_ERR`≠0, go to FAIL; else go to INIT_PWR.
- **INIT_PWR:** DP write, addr 1 (CTRL/STAT), data `PWRUP_VAL`.
- **INIT_SEL:** DP write, addr 2 (SELECT), data 0 (AP0, bank 0).
- After INIT_SEL, set `LINKUP`=1 and go to IDLE. Any error during init goes to FAIL.
- **FAIL:** `REQ_READY`=0, `LINKUP`=0. Leave only via `EN`=0.
- **IDLE:** `REQ_READY`=1. On handshake, latch the request.
  - If size is 3: go to RESP with `RSP_ERR`=3'b111 and no SWD traffic.
  - Else go to CSW if cached size is invalid or ≠ `REQ_SIZE`.
  - Else go to TAR if cached TAR is invalid or ≠ `REQ_ADDR`.
  - Else go to DRW.
- **CSW:** AP write, addr 0, data `CSW_BASE | size`. Update the size cache, then apply the TAR check.
- **TAR:** AP write, addr 1, data `REQ_ADDR`. Update the TAR cache, then go to DRW.
- **DRW:** AP addr 3. For a write, data is `REQ_WDATA`, then go to RESP. For a read, discard the posted result and go to RDBUFF.
- **RDBUFF:** DP read, addr 3. Capture `SWD_DATO` into `RSP_RDATA`, then go to RESP.
- **RESP:** pulse `RSP_VALID` for one cycle, then return to IDLE.

**Error handling.**
- Any nonzero `SWD_ERR` at done (after init): abort the sequence, pulse `SWD_CLR`, invalidate the CSW and TAR caches, set `RSP_ERR`=`SWD_ERR`, go to RESP.
- `RSP_RDATA` is unchanged on error.

## Timing
- **Reset values:** all outputs are 0; the state is OFF; caches are invalid.
- **Request acceptance:** `REQ_READY` is combinational from the state (IDLE only). It drops the cycle after acceptance.
- **First SWD issue:** `SWD_VALID` is asserted 1 cycle after acceptance, at the earliest.
- **Illegal size:** `RSP_VALID` is asserted exactly 2 cycles after acceptance.
- **Response hold:** `RSP_RDATA`/`RSP_ERR` are held until the next `RSP_VALID`.
- **Next request:** `REQ_READY` returns the cycle after `RSP_VALID`.
- **`SWD_CLR`:** coincides with the cycle after the errored done.
- **`SWD_VALID` outputs:** `SWD_VALID` is never asserted twice without an intervening done. Its data and address outputs are registered and stable from issue until done.
- **`EN` low and `SWD_VALID` together:** `EN` falling in the same cycle as a `SWD_VALID` issue still goes to OFF. No response is produced.
- **Transaction counts:** cached word read of the same address = 2 SWD transactions; cold read = 4; cold write = 3.

## Test plan
- **Init:** `EN`=1, model returns clean IDCODE → DP writes CTRL/STAT = 0x5000_0000, then SELECT = 0; `LINKUP`=1; `REQ_READY`=1.
- **Cold word write:** addr 0x2000_0000, data 0xDEAD_BEEF → CSW = 0x2300_0002, TAR = 0x2000_0000, DRW = 0xDEAD_BEEF; `RSP_ERR`=0.
- **Read after that write:** same address, word → only DRW read + RDBUFF; `RSP_RDATA` = model value 0x1234_5678.
- **Byte read:** addr 0x2000_0001 → CSW rewritten to 0x2300_0000 and TAR to 0x2000_0001. Then a word access to 0x2000_0001 rewrites CSW only.
- **FAULT on DRW:** `SWD_ERR`=1 → `SWD_CLR` pulse, `RSP_ERR`=1. The next request reissues CSW and TAR.
- **Edge cases:** `REQ_SIZE`=3 → `RSP_ERR`=7 with zero `SWD_VALID` pulses. `EN` dropped mid-TAR → no `RSP_VALID`, `LINKUP`=0. Re-enable → full init repeats.

Source files
------------

// File: rtl/swd_memap_seq.sv
// Memory-access sequencer in front of swd_if: turns 32-bit memory reads/writes into
// DP/AP transactions (power-up, SELECT, CSW, TAR, DRW, RDBUFF) with CSW-size/TAR caching.
`timescale 1ns/1ps
module swd_memap_seq #(
  parameter logic [31:0] CSW_BASE  = 32'h2300_0000,
  parameter logic [31:0] PWRUP_VAL = 32'h5000_0000
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        EN,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  input  logic        REQ_WRITE,
  input  logic [1:0]  REQ_SIZE,
  output logic        RSP_VALID,
  output logic [31:0] RSP_RDATA,
  output logic [2:0]  RSP_ERR,
  output logic        LINKUP,
  output logic        SWD_APNDP,
  output logic [1:0]  SWD_ADDR,
  output logic [31:0] SWD_DATI,
  output logic        SWD_WRITE,
  output logic        SWD_VALID,
  input  logic        SWD_READY,
  input  logic [31:0] SWD_DATO,
  input  logic [2:0]  SWD_ERR,
  output logic        SWD_CLR
);

  localparam int unsigned DW = 32;
  localparam int unsigned EW = 3;
  localparam int unsigned SW = 2;
  localparam int unsigned AW = 2;

  localparam logic [3:0] S_OFF       = 4'd0;
  localparam logic [3:0] S_WAIT_LINK = 4'd1;
  localparam logic [3:0] S_INIT_PWR  = 4'd2;
  localparam logic [3:0] S_INIT_SEL  = 4'd3;
  localparam logic [3:0] S_IDLE      = 4'd4;
  localparam logic [3:0] S_CSW       = 4'd5;
  localparam logic [3:0] S_TAR       = 4'd6;
  localparam logic [3:0] S_DRW       = 4'd7;
  localparam logic [3:0] S_RDBUFF    = 4'd8;
  localparam logic [3:0] S_RESP      = 4'd9;
  localparam logic [3:0] S_FAIL      = 4'd10;

  localparam logic [EW-1:0] ERR_SIZE = 3'b111;

  logic [3:0]    state_q, state_d;
  logic          issued_q, issued_d;
  logic          seen_low_q, seen_low_d;
  logic          swd_valid_q, swd_valid_d;
  logic          swd_apndp_q, swd_apndp_d;
  logic [AW-1:0] swd_addr_q, swd_addr_d;
  logic [DW-1:0] swd_dati_q, swd_dati_d;
  logic          swd_write_q, swd_write_d;
  logic          swd_clr_q, swd_clr_d;
  logic          linkup_q, linkup_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [EW-1:0] rsp_err_q, rsp_err_d;
  logic [DW-1:0] rdata_pend_q, rdata_pend_d;
  logic [EW-1:0] err_pend_q, err_pend_d;
  logic [DW-1:0] req_addr_q, req_addr_d;
  logic [DW-1:0] req_wdata_q, req_wdata_d;
  logic          req_write_q, req_write_d;
  logic [SW-1:0] req_size_q, req_size_d;
  logic          csw_vld_q, csw_vld_d;
  logic [SW-1:0] csw_size_q, csw_size_d;
  logic          tar_vld_q, tar_vld_d;
  logic [DW-1:0] tar_addr_q, tar_addr_d;

  logic          iss_apndp;
  logic [AW-1:0] iss_addr;
  logic          iss_write;
  logic [DW-1:0] iss_dati;
  logic          swd_state;
  logic          done;
  logic          err_c;
  logic          abort;
  logic          tar_hit;

  assign REQ_READY = (state_q == S_IDLE) && EN;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_RDATA = rsp_rdata_q;
  assign RSP_ERR   = rsp_err_q;
  assign LINKUP    = linkup_q;
  assign SWD_APNDP = swd_apndp_q;
  assign SWD_ADDR  = swd_addr_q;
  assign SWD_DATI  = swd_dati_q;
  assign SWD_WRITE = swd_write_q;
  assign SWD_VALID = swd_valid_q;
  assign SWD_CLR   = swd_clr_q;

  assign swd_state = (state_q == S_INIT_PWR) || (state_q == S_INIT_SEL) ||
                     (state_q == S_CSW) || (state_q == S_TAR) ||
                     (state_q == S_DRW) || (state_q == S_RDBUFF);
  // done = READY rising again after it dropped in response to our issue
  assign done    = issued_q && seen_low_q && SWD_READY;
  assign err_c   = (SWD_ERR != '0);
  assign abort   = done && err_c && (state_q == S_CSW || state_q == S_TAR ||
                                     state_q == S_DRW || state_q == S_RDBUFF);
  assign tar_hit = tar_vld_q && (tar_addr_q == req_addr_q);

  // Transaction fields for the current SWD state
  always_comb begin
    iss_apndp = 1'b0;
    iss_addr  = '0;
    iss_write = 1'b1;
    iss_dati  = '0;
    case (state_q)
      S_INIT_PWR: begin iss_addr = 2'd1; iss_dati = PWRUP_VAL; end
      S_INIT_SEL: iss_addr = 2'd2;
      S_CSW:      begin iss_apndp = 1'b1; iss_dati = CSW_BASE | DW'(req_size_q); end
      S_TAR:      begin iss_apndp = 1'b1; iss_addr = 2'd1; iss_dati = req_addr_q; end
      S_DRW: begin
        iss_apndp = 1'b1;
        iss_addr  = 2'd3;
        iss_write = req_write_q;
        iss_dati  = req_write_q ? req_wdata_q : '0;
      end
      S_RDBUFF:   begin iss_addr = 2'd3; iss_write = 1'b0; end
      default: ;
    endcase
  end

  // Next-state and output logic
  always_comb begin
    state_d      = state_q;
    issued_d     = issued_q;
    seen_low_d   = seen_low_q;
    swd_valid_d  = 1'b0;
    swd_apndp_d  = swd_apndp_q;
    swd_addr_d   = swd_addr_q;
    swd_dati_d   = swd_dati_q;
    swd_write_d  = swd_write_q;
    swd_clr_d    = 1'b0;
    linkup_d     = linkup_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    rdata_pend_d = rdata_pend_q;
    err_pend_d   = err_pend_q;
    req_addr_d   = req_addr_q;
    req_wdata_d  = req_wdata_q;
    req_write_d  = req_write_q;
    req_size_d   = req_size_q;
    csw_vld_d    = csw_vld_q;
    csw_size_d   = csw_size_q;
    tar_vld_d    = tar_vld_q;
    tar_addr_d   = tar_addr_q;

    if (swd_state && !issued_q && SWD_READY) begin
      swd_valid_d = 1'b1;
      issued_d    = 1'b1;
      swd_apndp_d = iss_apndp;
      swd_addr_d  = iss_addr;
      swd_dati_d  = iss_dati;
      swd_write_d = iss_write;
    end
    if (issued_q && !SWD_READY) seen_low_d = 1'b1;

    case (state_q)
      S_OFF: begin
        linkup_d  = 1'b0;
        csw_vld_d = 1'b0;
        tar_vld_d = 1'b0;
        if (EN) state_d = S_WAIT_LINK;
      end
      S_WAIT_LINK: if (SWD_READY) state_d = err_c ? S_FAIL : S_INIT_PWR;
      S_INIT_PWR:  if (done) state_d = err_c ? S_FAIL : S_INIT_SEL;
      S_INIT_SEL: if (done) begin
        if (err_c) state_d = S_FAIL;
        else begin
          linkup_d = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_IDLE: if (REQ_VALID) begin
        req_addr_d  = REQ_ADDR;
        req_wdata_d = REQ_WDATA;
        req_write_d = REQ_WRITE;
        req_size_d  = REQ_SIZE;
        err_pend_d  = '0;
        if (REQ_SIZE == 2'd3) begin
          err_pend_d = ERR_SIZE;
          state_d    = S_RESP;
        end else if (!csw_vld_q || csw_size_q != REQ_SIZE) state_d = S_CSW;
        else if (!tar_vld_q || tar_addr_q != REQ_ADDR)      state_d = S_TAR;
        else                                               state_d = S_DRW;
      end
      S_CSW: if (done && !err_c) begin
        csw_vld_d  = 1'b1;
        csw_size_d = req_size_q;
        state_d    = tar_hit ? S_DRW : S_TAR;
      end
      S_TAR: if (done && !err_c) begin
        tar_vld_d  = 1'b1;
        tar_addr_d = req_addr_q;
        state_d    = S_DRW;
      end
      S_DRW:    if (done && !err_c) state_d = req_write_q ? S_RESP : S_RDBUFF;
      S_RDBUFF: if (done && !err_c) begin
        rdata_pend_d = SWD_DATO;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = err_pend_q;
          if (err_pend_q == '0 && !req_write_q) rsp_rdata_d = rdata_pend_q;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FAIL: linkup_d = 1'b0;
      default: state_d = S_OFF;
    endcase

    if (abort) begin
      swd_clr_d  = 1'b1;
      csw_vld_d  = 1'b0;
      tar_vld_d  = 1'b0;
      err_pend_d = SWD_ERR;
      state_d    = S_RESP;
    end

    // Link disable wins over everything and drops any request in flight
    if (!EN) begin
      state_d     = S_OFF;
      swd_valid_d = 1'b0;
      linkup_d    = 1'b0;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
    end

    if (state_d != state_q) begin
      issued_d   = 1'b0;
      seen_low_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q      <= S_OFF;
      issued_q     <= 1'b0;
      seen_low_q   <= 1'b0;
      swd_valid_q  <= 1'b0;
      swd_apndp_q  <= 1'b0;
      swd_addr_q   <= '0;
      swd_dati_q   <= '0;
      swd_write_q  <= 1'b0;
      swd_clr_q    <= 1'b0;
      linkup_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= '0;
      rdata_pend_q <= '0;
      err_pend_q   <= '0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      req_write_q  <= 1'b0;
      req_size_q   <= '0;
      csw_vld_q    <= 1'b0;
      csw_size_q   <= '0;
      tar_vld_q    <= 1'b0;
      tar_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      issued_q     <= issued_d;
      seen_low_q   <= seen_low_d;
      swd_valid_q  <= swd_valid_d;
      swd_apndp_q  <= swd_apndp_d;
      swd_addr_q   <= swd_addr_d;
      swd_dati_q   <= swd_dati_d;
      swd_write_q  <= swd_write_d;
      swd_clr_q    <= swd_clr_d;
      linkup_q     <= linkup_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      rdata_pend_q <= rdata_pend_d;
      err_pend_q   <= err_pend_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
      req_write_q  <= req_write_d;
      req_size_q   <= req_size_d;
      csw_vld_q    <= csw_vld_d;
      csw_size_q   <= csw_size_d;
      tar_vld_q    <= tar_vld_d;
      tar_addr_q   <= tar_addr_d;
    end
  end

endmodule

// File: tb/tb_swd_memap_seq.sv
// Bench for swd_memap_seq: behavioural swd_if responder, expected-transaction scoreboard,
// table of memory requests plus hand-written init / link-drop sequences.
`timescale 1ns/1ps
module tb_swd_memap_seq;

  localparam logic [31:0] CSW_BASE  = 32'h2300_0000;
  localparam logic [31:0] PWRUP_VAL = 32'h5000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_write;
  logic [1:0]  req_size;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [2:0]  rsp_err;
  logic        linkup;
  logic        swd_apndp;
  logic [1:0]  swd_addr;
  logic [31:0] swd_dati;
  logic        swd_write;
  logic        swd_valid;
  logic        swd_clr;

  logic        m_ready;
  logic [31:0] m_dato;
  logic [2:0]  m_err;
  int          m_busy;
  int          m_boot;
  logic [31:0] m_pend_dato;
  logic [2:0]  m_pend_err;
  logic [31:0] m_rd_val;
  logic [2:0]  inj_drw_err;
  logic [2:0]  inj_rdb_err;

  int checks = 0;
  int errors = 0;
  int clr_cnt = 0;
  logic prev_valid = 1'b0;

  typedef struct {
    logic        write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [2:0]  drw_err;
    logic [2:0]  rdb_err;
  } vec_t;

  typedef struct {
    logic        apndp;
    logic [1:0]  addr;
    logic        write;
    logic [31:0] dati;
  } txn_t;

  txn_t exp_q[$];

  // bench-side reference caches
  logic        c_size_vld;
  logic [1:0]  c_size;
  logic        c_tar_vld;
  logic [31:0] c_tar;
  logic [31:0] last_rdata = 32'h0;

  always #5 clk = ~clk;

  swd_memap_seq #(.CSW_BASE(CSW_BASE), .PWRUP_VAL(PWRUP_VAL)) dut (
    .CLK(clk), .RESETn(rst_n), .EN(en),
    .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_ADDR(req_addr),
    .REQ_WDATA(req_wdata), .REQ_WRITE(req_write), .REQ_SIZE(req_size),
    .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata), .RSP_ERR(rsp_err), .LINKUP(linkup),
    .SWD_APNDP(swd_apndp), .SWD_ADDR(swd_addr), .SWD_DATI(swd_dati),
    .SWD_WRITE(swd_write), .SWD_VALID(swd_valid), .SWD_READY(m_ready),
    .SWD_DATO(m_dato), .SWD_ERR(m_err), .SWD_CLR(swd_clr)
  );

  // swd_if responder: IDCODE phase after EN, then 3 busy cycles per transaction
  always @(posedge clk) begin
    if (!rst_n || !en) begin
      m_ready <= 1'b0; m_busy <= 0; m_boot <= 0; m_err <= 3'd0; m_dato <= 32'h0;
      m_pend_dato <= 32'h0; m_pend_err <= 3'd0;
    end else begin
      if (swd_clr) m_err <= 3'd0;
      if (m_boot < 4) begin
        m_boot <= m_boot + 1;
        if (m_boot == 3) m_ready <= 1'b1;
      end else if (m_busy > 0) begin
        m_busy <= m_busy - 1;
        if (m_busy == 1) begin
          m_ready <= 1'b1; m_dato <= m_pend_dato; m_err <= m_pend_err;
        end
      end else if (m_ready && swd_valid) begin
        m_ready <= 1'b0;
        m_busy  <= 3;
        if (swd_apndp && swd_addr == 2'd3) begin
          m_pend_dato <= 32'hBAD0_BAD0; m_pend_err <= inj_drw_err;
        end else if (!swd_apndp && swd_addr == 2'd3 && !swd_write) begin
          m_pend_dato <= m_rd_val; m_pend_err <= inj_rdb_err;
        end else begin
          m_pend_dato <= 32'h0; m_pend_err <= 3'd0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_txn(input logic ap, input logic [1:0] a, input logic w, input logic [31:0] d);
    txn_t t;
    t.apndp = ap; t.addr = a; t.write = w; t.dati = d;
    exp_q.push_back(t);
  endtask

  // SWD transaction monitor / scoreboard pop
  always @(negedge clk) begin
    txn_t t;
    if (swd_clr) clr_cnt++;
    if (swd_valid) begin
      chk("swd_valid_protocol", 32'(m_ready && !prev_valid), 32'd1);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL swd_unexpected_txn: got apndp=%0d addr=%0d write=%0d dati=0x%08h expected none",
                 swd_apndp, swd_addr, swd_write, swd_dati);
      end else begin
        t = exp_q.pop_front();
        chk("swd_apndp_addr_write", {28'h0, swd_apndp, swd_addr, swd_write},
            {28'h0, t.apndp, t.addr, t.write});
        if (t.write) chk("swd_dati", swd_dati, t.dati);
      end
    end
    prev_valid = swd_valid;
  end

  // Reference sequencing: queue expected SWD traffic, compute expected response
  task automatic model_push(input vec_t v, output logic [2:0] e_err, output logic [31:0] e_rdata);
    e_err = 3'd0;
    e_rdata = last_rdata;
    if (v.size == 2'd3) begin
      e_err = 3'b111;
      return;
    end
    if (!c_size_vld || c_size != v.size) begin
      push_txn(1'b1, 2'd0, 1'b1, CSW_BASE | 32'(v.size));
      c_size_vld = 1'b1; c_size = v.size;
    end
    if (!c_tar_vld || c_tar != v.addr) begin
      push_txn(1'b1, 2'd1, 1'b1, v.addr);
      c_tar_vld = 1'b1; c_tar = v.addr;
    end
    push_txn(1'b1, 2'd3, v.write, v.wdata);
    if (v.drw_err != 3'd0) begin
      e_err = v.drw_err; c_size_vld = 1'b0; c_tar_vld = 1'b0;
      return;
    end
    if (!v.write) begin
      push_txn(1'b0, 2'd3, 1'b0, 32'h0);
      if (v.rdb_err != 3'd0) begin
        e_err = v.rdb_err; c_size_vld = 1'b0; c_tar_vld = 1'b0;
      end else begin
        e_rdata = v.rdata; last_rdata = v.rdata;
      end
    end
  endtask

  task automatic do_init();
    int lat;
    c_size_vld = 1'b0; c_tar_vld = 1'b0;
    push_txn(1'b0, 2'd1, 1'b1, PWRUP_VAL);
    push_txn(1'b0, 2'd2, 1'b1, 32'h0);
    en = 1'b1;
    lat = 0;
    while (!linkup && lat < 300) begin @(negedge clk); lat++; end
    chk("init_linkup", 32'(linkup), 32'd1);
    chk("init_txn_left", 32'(exp_q.size()), 32'd0);
    chk("init_req_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    int clr0;
    logic [2:0] e_err;
    logic [31:0] e_rdata;
    lat = 0;
    while (!req_ready && lat < 200) begin @(negedge clk); lat++; end
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    inj_drw_err = v.drw_err; inj_rdb_err = v.rdb_err; m_rd_val = v.rdata;
    model_push(v, e_err, e_rdata);
    clr0 = clr_cnt;
    req_valid = 1'b1; req_addr = v.addr; req_wdata = v.wdata;
    req_write = v.write; req_size = v.size;
    @(negedge clk);
    req_valid = 1'b0;
    chk("req_ready_drop", 32'(req_ready), 32'd0);
    lat = 1;
    while (!rsp_valid && lat < 400) begin @(negedge clk); lat++; end
    chk("rsp_seen", 32'(rsp_valid), 32'd1);
    chk("rsp_err", 32'(rsp_err), 32'(e_err));
    chk("rsp_rdata", rsp_rdata, e_rdata);
    chk("txn_left", 32'(exp_q.size()), 32'd0);
    if (v.size == 2'd3) chk("illegal_latency", 32'(lat), 32'd2);
    @(negedge clk);
    chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);
    chk("req_ready_back", 32'(req_ready), 32'd1);
    chk("swd_clr_pulses", 32'(clr_cnt - clr0), (e_err != 3'd0 && e_err != 3'b111) ? 32'd1 : 32'd0);
  endtask

  initial begin
    vec_t vecs[10];
    vec_t cold;
    int lat;
    int rsp_cnt;
    en = 1'b0; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_write = 1'b0;
    req_size = '0; m_rd_val = '0; inj_drw_err = '0; inj_rdb_err = '0;

    //        write size addr           wdata          rdata          drw  rdb
    vecs[0] = '{1'b1, 2'd2, 32'h2000_0000, 32'hDEAD_BEEF, 32'h0,         3'd0, 3'd0};
    vecs[1] = '{1'b0, 2'd2, 32'h2000_0000, 32'h0,         32'h1234_5678, 3'd0, 3'd0};
    vecs[2] = '{1'b0, 2'd0, 32'h2000_0001, 32'h0,         32'hA5A5_A5A5, 3'd0, 3'd0};
    vecs[3] = '{1'b0, 2'd2, 32'h2000_0001, 32'h0,         32'h0BAD_F00D, 3'd0, 3'd0};
    vecs[4] = '{1'b1, 2'd1, 32'h2000_0004, 32'h1111_2222, 32'h0,         3'd1, 3'd0};
    vecs[5] = '{1'b1, 2'd1, 32'h2000_0004, 32'h3333_4444, 32'h0,         3'd0, 3'd0};
    vecs[6] = '{1'b0, 2'd3, 32'h2000_0004, 32'h0,         32'h0,         3'd0, 3'd0};
    vecs[7] = '{1'b0, 2'd2, 32'h2000_0004, 32'h0,         32'h7777_7777, 3'd0, 3'd2};
    vecs[8] = '{1'b0, 2'd2, 32'h2000_0004, 32'h0,         32'hCAFE_F00D, 3'd0, 3'd0};
    vecs[9] = '{1'b1, 2'd0, 32'h2000_0003, 32'hAB00_0000, 32'h0,         3'd0, 3'd0};
    cold    = '{1'b0, 2'd2, 32'h2000_0008, 32'h0,         32'h55AA_33CC, 3'd0, 3'd0};

    repeat (3) @(negedge clk);
    chk("reset_linkup", 32'(linkup), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_swd_valid", 32'(swd_valid), 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_swd_clr", 32'(swd_clr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_init();
    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Link dropped while TAR is in flight: no response, link down
    lat = 0;
    while (!req_ready && lat < 200) begin @(negedge clk); lat++; end
    push_txn(1'b1, 2'd0, 1'b1, CSW_BASE | 32'd2);
    push_txn(1'b1, 2'd1, 1'b1, 32'h2000_0008);
    req_valid = 1'b1; req_addr = 32'h2000_0008; req_wdata = 32'h0F0F_0F0F;
    req_write = 1'b1; req_size = 2'd2;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!(swd_valid && swd_apndp && swd_addr == 2'd1) && lat < 200) begin
      @(negedge clk); lat++;
    end
    chk("drop_tar_issued", 32'(swd_valid), 32'd1);
    @(negedge clk);
    en = 1'b0;
    rsp_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid) rsp_cnt++;
    end
    chk("drop_no_rsp", 32'(rsp_cnt), 32'd0);
    chk("drop_linkup", 32'(linkup), 32'd0);
    chk("drop_req_ready", 32'(req_ready), 32'd0);
    chk("drop_txn_left", 32'(exp_q.size()), 32'd0);

    do_init();
    run_vec(cold);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
